// File: rtl/datapath_pkg.sv
// Shared types for the sequenced datapath: opcode enums, sequencer states and the op register.
// Register indices are stored at DP_AW_MAX bits so one struct serves every NREGS build.
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        WB_C     = 2'b00,
        WB_PC    = 2'b01,
        WB_IMM8  = 2'b10,
        WB_MDATA = 2'b11
    } wb_sel_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } dp_state_t;

    localparam int DP_AW_MAX = 8;

    typedef struct packed {
        logic [DP_AW_MAX-1:0] rn;
        logic [DP_AW_MAX-1:0] rm;
        logic [DP_AW_MAX-1:0] rd;
        shift_op_t            shift_op;
        alu_op_t              alu_op;
        logic                 sel_a;
        logic                 sel_b;
        logic                 wr_rd;
    } dp_op_t;

endpackage

// File: rtl/datapath_seq_regfile.sv
// NREGS x WIDTH register file: one combinational read port, one write port, async clear.
module regfile_p #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(NREGS)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle execution unit: start -> LOAD_A -> LOAD_B -> EXEC -> WB with done pulse.
// Define DATAPATH_CARRY_EN to build the carry flag register; otherwise carry_out is tied 0.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      ready,
    output logic                      done,
    input  logic [$clog2(NREGS)-1:0]  rn,
    input  logic [$clog2(NREGS)-1:0]  rm,
    input  logic [$clog2(NREGS)-1:0]  rd,
    input  logic [1:0]                shift_op,
    input  logic [1:0]                alu_op,
    input  logic                      sel_a,
    input  logic                      sel_b,
    input  logic                      wr_rd,
    input  logic signed [WIDTH-1:0]   sximm5,
    input  logic                      w_en,
    input  logic [$clog2(NREGS)-1:0]  w_addr,
    input  logic [1:0]                wb_sel,
    input  logic signed [WIDTH-1:0]   mdata,
    input  logic [PC_W-1:0]           pc,
    input  logic signed [WIDTH-1:0]   sximm8,
    output logic signed [WIDTH-1:0]   datapath_out,
    output logic                      Z_out,
    output logic                      N_out,
    output logic                      V_out,
    output logic                      carry_out
);

    localparam int AW = $clog2(NREGS);

    function automatic logic signed [WIDTH-1:0] shift_b(input logic signed [WIDTH-1:0] b,
                                                        input shift_op_t sh);
        case (sh)
            SH_LSL:  return b <<< 1;
            SH_LSR:  return $signed($unsigned(b) >> 1);
            SH_ASR:  return b >>> 1;
            default: return b;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] alu_calc(input logic signed [WIDTH-1:0] ain,
                                                         input logic signed [WIDTH-1:0] bin,
                                                         input alu_op_t op);
        case (op)
            ALU_ADD: return ain + bin;
            ALU_SUB: return ain - bin;
            ALU_AND: return ain & bin;
            default: return ~bin;
        endcase
    endfunction

    function automatic logic ovf_calc(input logic signed [WIDTH-1:0] ain,
                                      input logic signed [WIDTH-1:0] bin,
                                      input logic signed [WIDTH-1:0] res,
                                      input alu_op_t op);
        case (op)
            ALU_ADD: return (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
            ALU_SUB: return (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
            default: return 1'b0;
        endcase
    endfunction

    dp_state_t               state;
    dp_op_t                  op, op_next;
    logic signed [WIDTH-1:0] op_imm;
    logic signed [WIDTH-1:0] a_p1, b_p2, c_p3;
    logic                    z_p3, n_p3, v_p3;
    logic                    ready_r, vld_p3;

    logic                    rf_we;
    logic [AW-1:0]           rf_waddr, rf_raddr;
    logic [WIDTH-1:0]        rf_wdata, rf_rdata;
    logic signed [WIDTH-1:0] ain, bin, alu_res;

    always_comb begin
        op_next          = '0;
        op_next.rn       = DP_AW_MAX'(rn);
        op_next.rm       = DP_AW_MAX'(rm);
        op_next.rd       = DP_AW_MAX'(rd);
        op_next.shift_op = shift_op_t'(shift_op);
        op_next.alu_op   = alu_op_t'(alu_op);
        op_next.sel_a    = sel_a;
        op_next.sel_b    = sel_b;
        op_next.wr_rd    = wr_rd;
    end

    // Writeback owns the port in WB; direct writes only reach it while idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = w_addr;
        rf_wdata = c_p3;
        if (state == S_WB) begin
            rf_we    = op.wr_rd;
            rf_waddr = op.rd[AW-1:0];
        end else if (ready_r && w_en) begin
            rf_we = 1'b1;
            case (wb_sel_t'(wb_sel))
                WB_PC:    rf_wdata = WIDTH'(pc);
                WB_IMM8:  rf_wdata = sximm8;
                WB_MDATA: rf_wdata = mdata;
                default:  rf_wdata = c_p3;
            endcase
        end
    end

    assign rf_raddr = (state == S_LOAD_A) ? op.rn[AW-1:0] : op.rm[AW-1:0];

    regfile_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    assign ain     = op.sel_a ? '0 : a_p1;
    assign bin     = op.sel_b ? op_imm : shift_b(b_p2, op.shift_op);
    assign alu_res = alu_calc(ain, bin, op.alu_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
            vld_p3  <= 1'b0;
            op      <= '0;
            op_imm  <= '0;
            a_p1    <= '0;
            b_p2    <= '0;
            c_p3    <= '0;
            z_p3    <= 1'b0;
            n_p3    <= 1'b0;
            v_p3    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op      <= op_next;
                        op_imm  <= sximm5;
                        state   <= S_LOAD_A;
                        ready_r <= 1'b0;
                    end
                end
                // p1: A operand
                S_LOAD_A: begin
                    a_p1  <= $signed(rf_rdata);
                    state <= S_LOAD_B;
                end
                // p2: B operand
                S_LOAD_B: begin
                    b_p2  <= $signed(rf_rdata);
                    state <= S_EXEC;
                end
                // p3: result and flags
                S_EXEC: begin
                    c_p3   <= alu_res;
                    z_p3   <= (alu_res == '0);
                    n_p3   <= alu_res[WIDTH-1];
                    v_p3   <= ovf_calc(ain, bin, alu_res, op.alu_op);
                    vld_p3 <= 1'b1;
                    state  <= S_WB;
                end
                // A start held through WB chains straight into the next op.
                S_WB: begin
                    vld_p3 <= 1'b0;
                    if (start) begin
                        op     <= op_next;
                        op_imm <= sximm5;
                        state  <= S_LOAD_A;
                    end else begin
                        state   <= S_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                    vld_p3  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DATAPATH_CARRY_EN
    function automatic logic carry_calc(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input alu_op_t op_sel);
        logic [WIDTH:0] ext;
        case (op_sel)
            ALU_ADD: ext = {1'b0, a} + {1'b0, b};
            ALU_SUB: ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            default: ext = '0;
        endcase
        return ext[WIDTH];
    endfunction

    logic carry_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               carry_p3 <= 1'b0;
        else if (state == S_EXEC) carry_p3 <= carry_calc(ain, bin, op.alu_op);
    end

    assign carry_out = carry_p3;
`else
    assign carry_out = 1'b0;
`endif

    assign ready        = ready_r;
    assign done         = vld_p3;
    assign datapath_out = c_p3;
    assign Z_out        = z_p3;
    assign N_out        = n_p3;
    assign V_out        = v_p3;

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: expected results queued at start, checked on done.
module tb_datapath_seq;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int PC_W  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready, done;
    logic [2:0]  rn = '0, rm = '0, rd = '0, w_addr = '0;
    logic [1:0]  shift_op = '0, alu_op = '0, wb_sel = '0;
    logic        sel_a = 1'b0, sel_b = 1'b0, wr_rd = 1'b0, w_en = 1'b0;
    logic [15:0] sximm5 = '0, mdata = '0, sximm8 = '0;
    logic [7:0]  pc = '0;
    logic [15:0] datapath_out;
    logic        Z_out, N_out, V_out, carry_out;

    typedef struct {
        logic [15:0] res;
        logic        z, n, v, c;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_r [NREGS];
    logic [15:0] model_c;
    int          errors = 0;
    int          checks = 0;

    datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .done(done),
        .rn(rn), .rm(rm), .rd(rd), .shift_op(shift_op), .alu_op(alu_op),
        .sel_a(sel_a), .sel_b(sel_b), .wr_rd(wr_rd), .sximm5(sximm5),
        .w_en(w_en), .w_addr(w_addr), .wb_sel(wb_sel), .mdata(mdata), .pc(pc),
        .sximm8(sximm8), .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out),
        .V_out(V_out), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_op(input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] sh, input logic [1:0] alu,
                                      input logic sa, input logic sb, input logic [15:0] imm);
        logic [15:0] ain, bsh, bin;
        int          ia, ib, s;
        exp_t        e;
        ain = sa ? 16'h0000 : a;
        case (sh)
            2'd0:    bsh = b;
            2'd1:    bsh = {b[14:0], 1'b0};
            2'd2:    bsh = {1'b0, b[15:1]};
            default: bsh = {b[15], b[15:1]};
        endcase
        bin = sb ? imm : bsh;
        ia  = $signed(ain);
        ib  = $signed(bin);
        e.v = 1'b0;
        e.c = 1'b0;
        case (alu)
            2'd0: begin
                s     = ia + ib;
                e.res = ain + bin;
                e.v   = (s > 32767) || (s < -32768);
                e.c   = (int'(ain) + int'(bin)) > 65535;
            end
            2'd1: begin
                s     = ia - ib;
                e.res = ain - bin;
                e.v   = (s > 32767) || (s < -32768);
                e.c   = (ain >= bin);
            end
            2'd2:    e.res = ain & bin;
            default: e.res = ~bin;
        endcase
`ifndef DATAPATH_CARRY_EN
        e.c = 1'b0;
`endif
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        return e;
    endfunction

    // Entered and left on a falling edge.
    task automatic do_write(input logic [2:0] addr, input logic [1:0] sel, input logic [15:0] val);
        w_en   = 1'b1;
        w_addr = addr;
        wb_sel = sel;
        case (sel)
            2'd0: model_r[addr] = model_c;
            2'd1: begin pc = val[7:0]; model_r[addr] = {8'h00, val[7:0]}; end
            2'd2: begin sximm8 = val; model_r[addr] = val; end
            default: begin mdata = val; model_r[addr] = val; end
        endcase
        @(negedge clk);
        w_en = 1'b0;
    endtask

    task automatic compare_out(input string nm, input exp_t e);
        checks++;
        if (datapath_out !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", nm, datapath_out, e.res);
        end
        checks++;
        if ({Z_out, N_out, V_out, carry_out} !== {e.z, e.n, e.v, e.c}) begin
            errors++;
            $display("FAIL %s flags ZNVC: got %b expected %b", nm,
                     {Z_out, N_out, V_out, carry_out}, {e.z, e.n, e.v, e.c});
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] rn_i, input logic [2:0] rm_i,
                          input logic [2:0] rd_i, input logic [1:0] sh, input logic [1:0] alu,
                          input logic sa, input logic sb, input logic wr, input logic [15:0] imm,
                          input logic wen_i = 1'b0, input logic [2:0] wad = 3'd0,
                          input logic [15:0] wval = 16'h0000);
        int   cnt;
        exp_t e;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", nm, ready);
        end
        rn = rn_i; rm = rm_i; rd = rd_i; shift_op = sh; alu_op = alu;
        sel_a = sa; sel_b = sb; wr_rd = wr; sximm5 = imm; start = 1'b1;
        if (wen_i) begin
            w_en = 1'b1; w_addr = wad; wb_sel = 2'd3; mdata = wval;
            model_r[wad] = wval;
        end
        sb_q.push_back(model_op(model_r[rn_i], model_r[rm_i], sh, alu, sa, sb, imm));
        @(negedge clk);
        start = 1'b0; w_en = 1'b0;
        rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
        shift_op = 2'($urandom); alu_op = 2'($urandom); sximm5 = 16'($urandom);
        sel_a = 1'($urandom); sel_b = 1'($urandom); wr_rd = 1'($urandom);
        cnt = 1;
        while (done !== 1'b1 && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done after 4 edges", nm);
            sb_q.delete();
        end else begin
            if (cnt != 4) begin
                errors++;
                $display("FAIL %s latency: got %0d edges expected 4", nm, cnt);
            end
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_in_wb: got %b expected 0", nm, ready);
            end
            e = sb_q.pop_front();
            compare_out(nm, e);
            model_c = e.res;
            if (wr) model_r[rd_i] = e.res;
            @(negedge clk);
            checks++;
            if ({done, ready} !== 2'b01) begin
                errors++;
                $display("FAIL %s after_wb done,ready: got %b expected 01", nm, {done, ready});
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ready, done, datapath_out, Z_out, N_out, V_out, carry_out} !== {2'b10, 16'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b done=%b out=%h ZNVC=%b expected ready=1 rest 0",
                     ready, done, datapath_out, {Z_out, N_out, V_out, carry_out});
        end
        for (int i = 0; i < NREGS; i++) model_r[i] = 16'h0000;
        model_c = 16'h0000;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        do_write(3'd2, 2'd3, 16'h0001);
        do_write(3'd3, 2'd3, 16'h0003);
        run_op("add", 3'd2, 3'd3, 3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_sub_shift();
        run_op("sub_lsl", 3'd2, 3'd3, 3'd5, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_not_asr();
        do_write(3'd4, 2'd3, 16'h801F);
        run_op("not_asr", 3'd2, 3'd4, 3'd6, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_overflow_zero();
        do_write(3'd0, 2'd2, 16'h7FFF);
        do_write(3'd1, 2'd1, 16'h0001);
        run_op("add_ovf", 3'd0, 3'd1, 3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        do_write(3'd0, 2'd3, 16'hFFFF);
        run_op("add_zero", 3'd0, 3'd1, 3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_operand_select();
        run_op("sub_imm_zero_a", 3'd4, 3'd4, 3'd6, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 16'hFFF0);
        run_op("and_lsr", 3'd3, 3'd4, 3'd6, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 16'h0);
        run_op("write_and_start", 3'd2, 3'd3, 3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0,
               1'b1, 3'd2, 16'h0010);
    endtask

    task automatic test_wb_sel();
        do_write(3'd6, 2'd0, 16'h0000);
        do_write(3'd7, 2'd1, 16'h00C3);
        do_write(3'd0, 2'd2, 16'h0000);
        run_op("readback_c", 3'd0, 3'd6, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        run_op("readback_pc", 3'd0, 3'd7, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_compare_only();
        run_op("cmp_sub", 3'd2, 3'd3, 3'd6, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0);
        run_op("cmp_readback", 3'd0, 3'd6, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_busy();
        exp_t e;
        int   extra;
        rn = 3'd2; rm = 3'd3; rd = 3'd5; shift_op = 2'd0; alu_op = 2'd0;
        sel_a = 1'b0; sel_b = 1'b0; wr_rd = 1'b1; start = 1'b1;
        sb_q.push_back(model_op(model_r[2], model_r[3], 2'd0, 2'd0, 1'b0, 1'b0, 16'h0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; w_en = 1'b1; w_addr = 3'd7; wb_sel = 2'd2; sximm8 = 16'h5555;
        @(negedge clk);
        start = 1'b0; w_en = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_done: got %b expected 1", done);
            sb_q.delete();
        end else begin
            e = sb_q.pop_front();
            compare_out("busy_op", e);
            model_c = e.res;
            model_r[5] = e.res;
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_no_second_op: got %0d extra done ready=%b expected 0 extra ready=1",
                     extra, ready);
        end
        run_op("busy_r7_readback", 3'd0, 3'd7, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        rn = 3'd2; rm = 3'd3; rd = 3'd5; shift_op = 2'd0; alu_op = 2'd0;
        sel_a = 1'b0; sel_b = 1'b0; wr_rd = 1'b1; start = 1'b1;
        sb_q.push_back(model_op(model_r[2], model_r[3], 2'd0, 2'd0, 1'b0, 1'b0, 16'h0));
        @(negedge clk);
        rn = 3'd5; rm = 3'd3; rd = 3'd6;
        for (int cnt = 2; cnt <= 9; cnt++) begin
            @(negedge clk);
            if (cnt == 4 || cnt == 8) begin
                checks++;
                if (done !== 1'b1 || sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_done_%0d: got %b expected 1", cnt, done);
                end else begin
                    e = sb_q.pop_front();
                    compare_out(cnt == 4 ? "b2b_first" : "b2b_second", e);
                    model_c = e.res;
                    if (cnt == 4) begin
                        model_r[5] = e.res;
                        sb_q.push_back(model_op(model_r[5], model_r[3], 2'd0, 2'd0,
                                                1'b0, 1'b0, 16'h0));
                    end else begin
                        model_r[6] = e.res;
                    end
                end
            end
            if (cnt == 5) begin
                start = 1'b0;
                checks++;
                if ({done, ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_reaccept done,ready: got %b expected 00", {done, ready});
                end
            end
            if (cnt == 9) begin
                checks++;
                if ({done, ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_idle done,ready: got %b expected 01", {done, ready});
                end
            end
        end
    endtask

    task automatic test_reset_exec();
        int extra;
        rn = 3'd2; rm = 3'd3; rd = 3'd5; shift_op = 2'd0; alu_op = 2'd1;
        sel_a = 1'b0; sel_b = 1'b0; wr_rd = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, done, datapath_out, Z_out, N_out, V_out, carry_out} !== {2'b10, 16'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_in_exec: got ready=%b done=%b out=%h ZNVC=%b expected ready=1 rest 0",
                     ready, done, datapath_out, {Z_out, N_out, V_out, carry_out});
        end
        for (int i = 0; i < NREGS; i++) model_r[i] = 16'h0000;
        model_c = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d done pulses expected 0", extra);
        end
        run_op("reset_r5_readback", 3'd0, 3'd5, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_shift();
        test_not_asr();
        test_overflow_zero();
        test_operand_select();
        test_wb_sel();
        test_compare_only();
        test_busy();
        test_back_to_back();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
